serial_add_ctrl: RTL and testbench

- Bit-serial adder controller. Sequences one instance of the team's one-bit full_adder cell over WIDTH clock cycles to add two WIDTH-bit operands.
- Handshake: start, busy and done.
- Used wherever area matters more than latency; sits between a register-file/host interface and the single full_adder datapath cell.

---
 rtl/serial_add_ctrl_pkg.sv | 19 +
 rtl/serial_add_ctrl_full_adder.sv | 16 +
 rtl/serial_add_ctrl.sv | 105 ++++++++++
 tb/tb_serial_add_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared constants and types for the bit-serial adder controller
//   DEFAULT_WIDTH : default operand/result width
//   state_t       : controller FSM encoding (IDLE, SHIFT, DONE)
//   cnt_width()   : bit-counter width for a given operand width (minimum 1)
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// full_adder: one-bit full adder cell
//   a, b, cin : operand bits and carry-in
//   sum       : a ^ b ^ cin
//   carry     : carry-out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencing one full_adder over WIDTH cycles
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : begin an addition (sampled only when idle)
//   a_in, b_in, cin_in: operands, captured on the accepting edge
//   busy              : high while shifting or reporting done
//   done              : one-cycle pulse when sum_out/cout_out are updated
//   sum_out, cout_out : last completed result, held until the next completion
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_sum, fa_carry;
    logic             load, shift, last;
    logic [WIDTH-1:0] s_next;

    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .carry(fa_carry)
    );

    assign load  = (state_q == ST_IDLE) && start;
    assign shift = (state_q == ST_SHIFT);
    assign last  = (cnt_q == CW'(WIDTH - 1));
    // New sum bit enters at the MSB; written as a shift so WIDTH=1 needs no special case.
    assign s_next = (s_sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = (state_q == ST_IDLE)  ? (start ? ST_SHIFT : ST_IDLE) :
                  (state_q == ST_SHIFT) ? (last  ? ST_DONE  : ST_SHIFT) :
                                          ST_IDLE;
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    always_comb begin
        a_sh_d  = load ? a_in   : shift ? a_sh_q >> 1    : a_sh_q;
        b_sh_d  = load ? b_in   : shift ? b_sh_q >> 1    : b_sh_q;
        s_sh_d  = load ? '0     : shift ? s_next         : s_sh_q;
        carry_d = load ? cin_in : shift ? fa_carry       : carry_q;
        cnt_d   = load ? '0     : shift ? cnt_q + 1'b1   : cnt_q;
        sum_d   = (shift && last) ? s_next   : sum_q;
        cout_d  = (shift && last) ? fa_carry : cout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum_out  = sum_q;
    assign cout_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       start1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin_in(cin8),
        .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin_in(cin1),
        .busy(busy1), .done(done1), .sum_out(sum1), .cout_out(cout1)
    );

    // Issue one add on dut8 and return at the negedge where done is seen.
    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int lat, output logic bsy, output logic chg);
        logic [7:0] s0;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        start8 = 1'b0; a8 = 'x; b8 = 'x;
        bsy = busy8; s0 = sum8; chg = 1'b0;
        while (!done8 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!done8 && sum8 !== s0) chg = 1'b1;
        end
    endtask

    task automatic add1(input logic a, input logic b, input logic c, output int lat);
        @(negedge clk);
        a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        start1 = 1'b0;
        while (!done1 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy8, done8, sum8, cout8} !== 10'b0) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b sum=%h cout=%b want all 0", busy8, done8, sum8, cout8);
        end
        checks++;
        if ({busy1, done1, sum1, cout1} !== 4'b0) begin
            errors++;
            $display("FAIL reset1 got busy=%b done=%b sum=%h cout=%b want all 0", busy1, done1, sum1, cout1);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat;
        logic bsy, chg;
        add8(8'h35, 8'h4A, 1'b0, lat, bsy, chg);
        checks++;
        if (bsy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", bsy); end
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
        checks++;
        if ({cout8, sum8} !== 9'h07F) begin errors++; $display("FAIL basic_sum got %b_%h want 0_7f", cout8, sum8); end
        checks++;
        if (chg !== 1'b0) begin errors++; $display("FAIL basic_partial sum_out moved during shift"); end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", done8); end
        checks++;
        if ({cout8, sum8} !== 9'h07F) begin errors++; $display("FAIL basic_hold got %b_%h want 0_7f", cout8, sum8); end
    endtask

    task automatic test_carry;
        int lat;
        logic bsy, chg;
        add8(8'hFF, 8'h01, 1'b0, lat, bsy, chg);
        checks++;
        if ({cout8, sum8} !== 9'h100) begin errors++; $display("FAIL carry_wrap got %b_%h want 1_00", cout8, sum8); end
        add8(8'hFF, 8'hFF, 1'b1, lat, bsy, chg);
        checks++;
        if ({cout8, sum8} !== 9'h1FF) begin errors++; $display("FAIL carry_full got %b_%h want 1_ff", cout8, sum8); end
        add8(8'h00, 8'h00, 1'b1, lat, bsy, chg);
        checks++;
        if ({cout8, sum8} !== 9'h001) begin errors++; $display("FAIL carry_cin got %b_%h want 0_01", cout8, sum8); end
    endtask

    task automatic test_start_while_busy;
        int pulses = 0;
        logic [7:0] res = '0;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done8) begin pulses++; res = sum8; end
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL busy_start_pulses got %0d want 1", pulses); end
        checks++;
        if (res !== 8'h30) begin errors++; $display("FAIL busy_start_sum got %h want 30", res); end
    endtask

    task automatic test_back_to_back;
        logic [16:0] vec [4] = '{{8'h12, 8'h34, 1'b0}, {8'hF0, 8'h0F, 1'b1},
                                 {8'h80, 8'h80, 1'b0}, {8'h7E, 8'h01, 1'b1}};
        logic [8:0] want;
        int t_prev = 0, n;
        @(negedge clk);
        {a8, b8, cin8} = vec[0];
        start8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (busy8 && n < 30) begin @(negedge clk); n++; end
            while (!busy8 && n < 30) begin @(negedge clk); n++; end
            want = {1'b0, vec[i][16:9]} + {1'b0, vec[i][8:1]} + {8'b0, vec[i][0]};
            {a8, b8, cin8} = (i < 3) ? vec[i+1] : 17'h1A5A5;
            if (i == 3) start8 = 1'b0;
            while (!done8 && n < 30) begin @(negedge clk); n++; end
            checks++;
            if ({cout8, sum8} !== want) begin
                errors++;
                $display("FAIL b2b_sum%0d got %b_%h want %b_%h", i, cout8, sum8, want[8], want[7:0]);
            end
            if (i > 0) begin
                checks++;
                if (cyc - t_prev !== 10) begin errors++; $display("FAIL b2b_period%0d got %0d want 10", i, cyc - t_prev); end
            end
            t_prev = cyc;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat;
        logic bsy, chg;
        add8(8'h35, 8'h4A, 1'b0, lat, bsy, chg);
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, sum8, cout8} !== 10'b0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b done=%b sum=%h cout=%b want all 0", busy8, done8, sum8, cout8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            checks++;
            if (done8 !== 1'b0) begin errors++; $display("FAIL reset_mid_done got %b want 0", done8); end
        end
        add8(8'h01, 8'h01, 1'b0, lat, bsy, chg);
        checks++;
        if ({cout8, sum8} !== 9'h002) begin errors++; $display("FAIL reset_mid_after got %b_%h want 0_02", cout8, sum8); end
    endtask

    task automatic test_width1;
        int lat;
        logic [1:0] want;
        for (int i = 0; i < 8; i++) begin
            add1(i[2], i[1], i[0], lat);
            want = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
            checks++;
            if ({cout1, sum1} !== want) begin errors++; $display("FAIL w1_sum%0d got %b%b want %b", i, cout1, sum1, want); end
            if (i == 0) begin
                checks++;
                if (lat !== 1) begin errors++; $display("FAIL w1_latency got %0d want 1", lat); end
            end
        end
    endtask

    task automatic test_random;
        int lat;
        logic bsy, chg;
        logic [7:0] a, b;
        logic c;
        logic [8:0] want;
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            want = {1'b0, a} + {1'b0, b} + {8'b0, c};
            add8(a, b, c, lat, bsy, chg);
            checks++;
            if ({cout8, sum8} !== want || lat !== 8 || chg !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d %h+%h+%b got %b_%h lat=%0d chg=%b want %b_%h lat=8", i, a, b, c,
                         cout8, sum8, lat, chg, want[8], want[7:0]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid;
        test_width1;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
